// File: rtl/hs_pkg.sv
// Shared types and default sizes for the sync-to-async transmit bridge.
package hs_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hs_tx_bridge_if.sv
// Bus bundle for hs_tx_bridge: clocked valid/ready input side, two-phase output side, status.
interface hs_tx_bridge_if import hs_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();

  // Input side: a word moves on a rising clock edge where io_In_Valid && io_In_Ready;
  // io_In_Data must be stable while io_In_Valid is high, and io_In_Ready never depends on io_In_Valid.
  logic             io_In_Valid;
  logic             io_In_Ready;
  logic [WIDTH-1:0] io_In_Data;
  logic             io_Out_HS_Req;
  logic             io_Out_HS_Ack;
  logic [WIDTH-1:0] io_Out_Data;
  logic             io_Busy;
  logic             io_Err;
  logic [15:0]      io_Sent_Count;

  modport slave (
    input  io_In_Valid, io_In_Data, io_Out_HS_Ack,
    output io_In_Ready, io_Out_HS_Req, io_Out_Data, io_Busy, io_Err, io_Sent_Count
  );

  modport master (
    output io_In_Valid, io_In_Data, io_Out_HS_Ack,
    input  io_In_Ready, io_Out_HS_Req, io_Out_Data, io_Busy, io_Err, io_Sent_Count
  );

endinterface

// File: rtl/hs_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module hs_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hs_tx_bridge.sv
// Buffers clocked words and issues each one as a single two-phase request transition,
// holding bundled data stable until the synchronized acknowledge matches.
module hs_tx_bridge import hs_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clock,
  input  logic           reset,
  hs_tx_bridge_if.slave  bus,
  output state_t         o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_req;
  logic [WIDTH-1:0] r_data;
  logic [15:0]      r_sent;
  logic             r_err;

  logic w_ack_s;
  logic w_ack_match;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_req_toggle;
  logic w_sent_inc;
  logic w_err_set;

  hs_sync2 u_ack_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.io_Out_HS_Ack),
    .o_q   (w_ack_s)
  );

  assign w_ack_match = (w_ack_s == r_req);
  assign w_ready     = (r_count < FULL);
  assign w_push      = bus.io_In_Valid && w_ready;
  // A mismatch outside WAIT can only come from an ack edge nobody asked for.
  assign w_err_set   = !w_ack_match && (r_state == IDLE || r_state == LOAD);

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_req_toggle = 1'b0;
    w_sent_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_req_toggle = 1'b1;
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        if (w_ack_match) begin
          w_sent_inc = 1'b1;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.io_In_Data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data is only reloaded on a pop, which happens only once the previous ack has matched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_sent  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_toggle) r_req  <= ~r_req;
      if (w_pop)        r_data <= r_mem[r_rd_ptr];
      if (w_sent_inc)   r_sent <= r_sent + 16'd1;
      if (w_err_set)    r_err  <= 1'b1;
    end
  end

  assign bus.io_In_Ready   = w_ready;
  assign bus.io_Out_HS_Req = r_req;
  assign bus.io_Out_Data   = r_data;
  assign bus.io_Busy       = (r_count != '0) || (r_state != IDLE);
  assign bus.io_Err        = r_err;
  assign bus.io_Sent_Count = r_sent;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_hs_tx_bridge.sv
// Directed bench for hs_tx_bridge: ordered-word scoreboard on every request edge plus timing pins.
module tb_hs_tx_bridge;
  import hs_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hs_tx_bridge_if #(.WIDTH(WIDTH)) bus ();
  state_t dbg_state;

  hs_tx_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Ack source: either a loopback that follows req after a delay, or manual control.
  logic use_man  = 1'b1;
  logic man_ack  = 1'b0;
  logic auto_ack = 1'b0;
  int   ack_cyc  = 0;
  assign bus.io_Out_HS_Ack = use_man ? man_ack : auto_ack;

  always begin
    @(bus.io_Out_HS_Req);
    if (ack_cyc == 0) begin
      #5;
    end else begin
      repeat (ack_cyc) @(posedge clock);
      #2;
    end
    auto_ack = bus.io_Out_HS_Req;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: words must leave in push order, one per req transition
  logic [WIDTH-1:0] exp_q[$];
  int               n_tog = 0;
  logic             prev_req = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             err_chk = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      n_tog     = 0;
      prev_req  = bus.io_Out_HS_Req;
      prev_data = bus.io_Out_Data;
    end else begin
      int s;
      if (bus.io_Out_HS_Req !== prev_req) begin
        n_tog++;
        check("word_pending_at_req", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("issued_word", bus.io_Out_Data, exp_q.pop_front());
      end else if (bus.io_Out_HS_Req !== bus.io_Out_HS_Ack) begin
        check("data_stable", bus.io_Out_Data, prev_data);
      end
      s = int'(bus.io_Sent_Count);
      check("sent_tracks_req", 32'((s <= n_tog) && (s + 1 >= n_tog)), 1);
      if (err_chk) check("err_clear", bus.io_Err, 0);
      prev_req  = bus.io_Out_HS_Req;
      prev_data = bus.io_Out_Data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    use_man = 1'b1;
    man_ack = 1'b0;
    err_chk = 1'b0;
    bus.io_In_Valid = 1'b0;
    exp_q.delete();
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 10 && auto_ack !== 1'b0; i++) step();
    check("auto_ack_settled", auto_ack, 0);
    err_chk = 1'b1;
  endtask

  task automatic push(input logic [WIDTH-1:0] w, output int waited);
    logic rdy;
    logic ok;
    waited = 0;
    ok = 1'b0;
    bus.io_In_Valid = 1'b1;
    bus.io_In_Data  = w;
    for (int i = 0; i < 500; i++) begin
      rdy = bus.io_In_Ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    bus.io_In_Valid = 1'b0;
    check("push_accepted", ok, 1);
    if (ok) exp_q.push_back(w);
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget && int'(bus.io_Sent_Count) != n; i++) step();
    check("sent_count_reached", bus.io_Sent_Count, n);
  endtask

  task automatic wait_tog(input int n, input int budget);
    for (int i = 0; i < budget && n_tog != n; i++) step();
    check("req_toggles_reached", n_tog, n);
  endtask

  initial begin
    int w;
    int first_low;
    bus.io_In_Valid = 1'b0;
    bus.io_In_Data  = '0;

    // reset values
    repeat (3) step();
    check("rst_req",   bus.io_Out_HS_Req, 0);
    check("rst_data",  bus.io_Out_Data, 0);
    check("rst_ready", bus.io_In_Ready, 1);
    check("rst_busy",  bus.io_Busy, 0);
    check("rst_err",   bus.io_Err, 0);
    check("rst_sent",  bus.io_Sent_Count, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    step();
    use_man = 1'b0;
    ack_cyc = 0;
    err_chk = 1'b1;

    // single word, 5 ns loopback ack
    push(8'hA5, w);
    step();
    check("single_data_k1",  bus.io_Out_Data, 8'hA5);
    check("single_req_k1",   bus.io_Out_HS_Req, 0);
    check("single_state_k1", dbg_state, LOAD);
    step();
    check("single_req_k2",   bus.io_Out_HS_Req, 1);
    step();
    step();
    check("single_sent_k4",  bus.io_Sent_Count, 0);
    check("single_busy_k4",  bus.io_Busy, 1);
    step();
    check("single_sent_k5",  bus.io_Sent_Count, 1);
    step();
    check("single_busy_k6",  bus.io_Busy, 0);

    // burst of 16 with the ack delayed 3 cycles
    do_reset();
    use_man = 1'b0;
    ack_cyc = 3;
    first_low = -1;
    for (int i = 0; i < 16; i++) begin
      push(8'(i), w);
      if (w > 0 && first_low < 0) first_low = i;
    end
    check("burst_accepted_before_full", first_low, 5);
    wait_sent(16, 400);
    step();
    check("burst_toggles", n_tog, 16);
    check("burst_queue_drained", exp_q.size(), 0);
    check("burst_err", bus.io_Err, 0);
    check("burst_busy_after", bus.io_Busy, 0);
    check("burst_ready_after", bus.io_In_Ready, 1);

    // data held while the ack is withheld
    do_reset();
    ack_cyc = 0;
    push(8'h11, w);
    wait_tog(1, 20);
    push(8'h3C, w);
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_data", bus.io_Out_Data, 8'h11);
    end
    check("hold_no_new_req", n_tog, 1);
    man_ack = bus.io_Out_HS_Req;
    wait_tog(2, 20);
    check("hold_next_word", bus.io_Out_Data, 8'h3C);
    man_ack = bus.io_Out_HS_Req;
    wait_sent(2, 20);

    // reset asserted while waiting on an ack with two words buffered
    push(8'h51, w);
    push(8'h52, w);
    push(8'h53, w);
    wait_tog(3, 20);
    step();
    check("mid_busy_before", bus.io_Busy, 1);
    check("mid_sent_before", bus.io_Sent_Count, 2);
    check("mid_state_before", dbg_state, WAIT);
    @(negedge clock);
    #2;
    reset   = 1'b0;
    man_ack = 1'b0;
    #1;
    exp_q.delete();
    check("mid_req",   bus.io_Out_HS_Req, 0);
    check("mid_data",  bus.io_Out_Data, 0);
    check("mid_ready", bus.io_In_Ready, 1);
    check("mid_busy",  bus.io_Busy, 0);
    check("mid_sent",  bus.io_Sent_Count, 0);
    check("mid_state", dbg_state, IDLE);
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    check("mid_words_discarded", n_tog, 0);
    check("mid_busy_after", bus.io_Busy, 0);

    // spurious ack while idle
    err_chk = 1'b0;
    man_ack = 1'b1;
    step();
    step();
    check("spur_err_e2", bus.io_Err, 0);
    step();
    check("spur_err_e3", bus.io_Err, 1);
    repeat (10) step();
    check("spur_err_sticky", bus.io_Err, 1);
    do_reset();
    check("spur_err_after_reset", bus.io_Err, 0);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
